// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetcher (IDLE/REQ/VALID) with branch redirect.
// Latency: word valid the cycle after mem_ack; two cycles from IDLE at best, one word per two cycles steady.
// Backpressure: stall holds the VALID word; dma_busy blocks new requests but never withdraws an issued one.
// Option macro FETCH_TIMEOUT_EN: abort a request after TIMEOUT_CYC cycles without mem_ack and pulse fetch_err.
module instr_fetch #(
  parameter int                ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] addr_q;
  logic              branch_pend;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic              ack_take;
  logic              timeout_hit;

  // An ack is only accepted when no redirect is pending or arriving; otherwise the word is stale.
  assign ack_take = (state == S_REQ) && mem_ack && !branch_pend && !branch_valid;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tcnt;
  logic          fetch_err_q;

  // Abort on the TIMEOUT_CYC-th REQ cycle that still has no ack; an ack in that cycle wins.
  assign timeout_hit = (state == S_REQ) && !mem_ack && (tcnt == TW'(TIMEOUT_CYC - 1));

  // Count REQ cycles from entry; cleared whenever REQ is not held over into the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt        <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= timeout_hit;
      if ((state == S_REQ) && (state_nxt == S_REQ)) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
    end
  end

  assign fetch_err = fetch_err_q;
`else
  logic unused_timeout;

  // Without the timeout option a request waits for its ack forever and never reports an error.
  assign timeout_hit    = 1'b0;
  assign fetch_err      = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  // State register; reset lands in IDLE immediately so mem_req drops without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: redirects win over starting a request; an issued request ends only on ack or timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!branch_valid && !dma_busy) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_nxt = ack_take ? S_VALID : S_IDLE;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_VALID: begin
        if (branch_valid) begin
          state_nxt = S_IDLE;
        end else if (!stall) begin
          state_nxt = dma_busy ? S_IDLE : S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded purely from the state register.
  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    case (state)
      S_REQ:   mem_req     = 1'b1;
      S_VALID: instr_valid = 1'b1;
      default: ;
    endcase
  end

  // PC, issued-address latch, pending-branch flag and the instruction output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      addr_q      <= RESET_PC;
      branch_pend <= 1'b0;
      instr_q     <= '0;
      pc_out_q    <= '0;
    end else begin
      if (branch_valid) begin
        pc <= branch_target;
      end else if (ack_take) begin
        pc <= pc + 1'b1;
      end

      // Latch the address only when a request starts so a mid-request redirect cannot move it.
      if ((state != S_REQ) && (state_nxt == S_REQ)) begin
        addr_q <= pc;
      end

      if (state == S_REQ) begin
        if (mem_ack || timeout_hit) begin
          branch_pend <= 1'b0;
        end else if (branch_valid) begin
          branch_pend <= 1'b1;
        end
      end else begin
        branch_pend <= 1'b0;
      end

      if (ack_take) begin
        instr_q  <= mem_rdata;
        pc_out_q <= pc;
      end
    end
  end

  assign mem_addr = addr_q;
  assign instr    = instr_q;
  assign opcode   = instr_q[31:26];
  assign pc_out   = pc_out_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, instruction-word address width.
REQ-002 SHALL provide parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 255, cycles in REQ without mem_ack before abort (used only under REQ-025).
REQ-004 SHALL have ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- dma_busy  input  1  DMA holds memory bus; no new request may start.
- mem_req  output  1  fetch request to memory.
- mem_addr  output  ADDR_W  fetch word address.
- mem_ack  input  1  memory returns mem_rdata this cycle.
- mem_rdata  input  32  instruction word.
- stall  input  1  downstream cannot accept instruction.
- branch_valid  input  1  redirect PC this cycle.
- branch_target  input  ADDR_W  redirect address.
- instr_valid  output  1  instr/opcode/pc_out valid for decode.
- instr  output  32  registered instruction.
- opcode  output  6  instr[31:26], feeds opcode decoder.
- pc_out  output  ADDR_W  address of instr.
- fetch_err  output  1  one-cycle pulse on fetch timeout.

Function
REQ-005 SHALL implement Moore FSM with states IDLE, REQ, VALID.
REQ-006 IDLE: dma_busy=0 -> REQ next cycle; dma_busy=1 -> stay IDLE.
REQ-007 REQ: mem_req=1, mem_addr=pc; mem_req SHALL be 0 in all other states.
REQ-008 REQ with mem_ack=1 and no pending branch: instr<=mem_rdata, pc_out<=pc, pc<=pc+1, -> VALID.
REQ-009 Once in REQ, dma_busy SHALL be ignored until mem_ack or timeout (no request withdrawal).
REQ-010 VALID: instr_valid=1; stall=1 -> hold all outputs unchanged.
REQ-011 VALID with stall=0: instruction consumed; -> REQ if dma_busy=0, else IDLE.
REQ-012 instr_valid SHALL be 1 only in VALID.
REQ-013 opcode SHALL equal instr[31:26] combinationally from the instr register; consumer qualifies with instr_valid.
REQ-014 pc+1 SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-015 branch_valid in IDLE: pc<=branch_target; stay IDLE.
REQ-016 branch_valid in VALID (stall ignored): pc<=branch_target, instruction flushed, -> IDLE, instr_valid=0 next cycle.
REQ-017 branch_valid in REQ: pc<=branch_target, set branch_pend; request stays asserted at original mem_addr until mem_ack.
REQ-018 mem_ack in REQ with branch_pend=1 or branch_valid=1 same cycle: mem_rdata discarded, pc not incremented, branch_pend cleared, -> IDLE.
REQ-019 mem_addr SHALL remain stable while mem_req=1 (REQ-017 updates pc, not the issued address latch).
REQ-020 Minimum latency: IDLE->instr_valid 2 cycles when memory acks in first REQ cycle; steady-state throughput one instruction per 2 cycles.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, branch_pend=0, timeout count=0.
REQ-022 Reset values: mem_req=0, mem_addr=RESET_PC, instr=0, opcode=0, pc_out=0, instr_valid=0, fetch_err=0.
REQ-023 Reset asserted mid-REQ SHALL drop mem_req asynchronously; any later mem_ack for that request is ignored.
REQ-024 First request after rst_n release SHALL start no earlier than the second rising edge.

Configuration
REQ-025 Macro FETCH_TIMEOUT_EN defined: count cycles in REQ from entry; reaching TIMEOUT_CYC without mem_ack -> mem_req=0, -> IDLE, fetch_err=1 for one cycle, pc unchanged (retry), branch_pend applied.
REQ-026 FETCH_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; fetch_err port present, tied 0.

Verification
REQ-027 Reset release, dma_busy=0, memory acks first REQ cycle with 0x00000000 -> mem_addr=0, instr_valid=1 two cycles later, opcode=0, pc_out=0, next mem_addr=1.
REQ-028 dma_busy=1 for 10 cycles in IDLE -> mem_req=0 for all 10; mem_req=1 the cycle after dma_busy falls.
REQ-029 VALID with stall=1 for 5 cycles, instr=0x8C000000 -> instr_valid=1, opcode=0x23 stable, no mem_req; stall=0 -> REQ next cycle.
REQ-030 branch_valid with target 0x3FF during REQ, ack 3 cycles later -> data discarded, instr_valid stays 0, next fetch mem_addr=0x3FF, following fetch mem_addr=0x000 (wrap).
REQ-031 FETCH_TIMEOUT_EN, TIMEOUT_CYC=255, mem_ack never -> mem_req drops after 255 REQ cycles, fetch_err pulses 1 cycle, retry fetches same mem_addr; without macro mem_req stays 1, fetch_err=0.
